vec_lane_seq: RTL and testbench
===============================

VEC_LANE_SEQ -- requirements
Module: vec_lane_seq

Interface
REQ-001 Parameter SIZE_V, default 8, SHALL set the number of elements per vector register.
REQ-002 Parameter REG_NUM, default 5, SHALL set the register-index width (32 vector registers).
REQ-003 Parameter DATA_LENGTH, default 8, SHALL set the element width in bits.
REQ-004 clk_i  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  SHALL be the reset: synchronous, active-high.
REQ-006 instr_valid_i  in  1  SHALL indicate that an instruction is offered.
REQ-007 instr_ready_o  out  1  SHALL indicate that the block accepts an instruction this cycle.
REQ-008 op_i  in  3  SHALL carry the opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 MINU, 111 MAXU.
REQ-009 vs1_i, vs2_i, vd_i  in  REG_NUM each  SHALL carry the source and destination register indices.
REQ-010 rd1_o, rd2_o  out  REG_NUM each  SHALL drive the register-file read addresses.
REQ-011 rd_valid_o  out  1  SHALL drive both register-file read valids.
REQ-012 s1_i, s2_i  in  DATA_LENGTH each  SHALL receive the register-file read data, registered one cycle after the read request.
REQ-013 wr_o  out  REG_NUM, wr_d_o  out  DATA_LENGTH, wr_valid_o  out  1  SHALL drive the register-file write port.
REQ-014 busy_o, done_o, illegal_o  out  1 each  SHALL flag, respectively: instruction in flight; single-cycle completion pulse; single-cycle illegal-op pulse.

Function
REQ-015 Handshake: an instruction SHALL be accepted on a rising edge where instr_valid_i and instr_ready_o are both 1; instr_ready_o = 1 only in IDLE.
REQ-016 FSM states: IDLE, READ, DRAIN; accept moves IDLE->READ and latches op, vs1, vs2 and vd.
REQ-017 READ: rd_valid_o = 1 for exactly SIZE_V consecutive cycles, with rd1_o/rd2_o held at the latched vs1/vs2; an element counter 0..SIZE_V-1 SHALL wrap to 0 and move the FSM to DRAIN after count SIZE_V-1.
REQ-018 Operand element k SHALL be sampled from s1_i/s2_i in the cycle after its read cycle; the result SHALL be registered, so wr_valid_o for element k is asserted 2 cycles after its rd_valid_o cycle.
REQ-019 wr_o = latched vd whenever wr_valid_o = 1; exactly SIZE_V writes per instruction, in element order 0..SIZE_V-1.
REQ-020 DRAIN SHALL last 2 cycles; done_o SHALL pulse together with the final wr_valid_o, then the FSM returns to IDLE.
REQ-021 Accept at edge T: reads occur in cycles T+1..T+SIZE_V, writes in T+3..T+SIZE_V+2, and instr_ready_o returns at T+SIZE_V+3.
REQ-022 Arithmetic: ADD, SUB and MUL SHALL wrap modulo 2^DATA_LENGTH (MUL keeps the low half); MINU/MAXU compare unsigned.
REQ-023 vd equal to vs1 or vs2 SHALL be legal: each element is read 2 cycles before it is written, so results are correct.
REQ-024 busy_o = 1 in READ and DRAIN; rd_valid_o, wr_valid_o, done_o and illegal_o SHALL be 0 outside the cycles stated above.

Reset
REQ-025 rst_i = 1 SHALL force IDLE, clear counters and the pipeline, and drive all outputs to 0 except instr_ready_o, which is 0 during reset and 1 from the first cycle after reset.
REQ-026 Reset mid-operation SHALL drop in-flight elements without further writes; realigning the register-file element index is a system-reset responsibility.

Configuration
REQ-027 With macro VEC_MUL_EN defined, op 101 SHALL execute MUL.
REQ-028 Without VEC_MUL_EN, op 101 SHALL be accepted, produce no reads and no writes, pulse illegal_o in the cycle after acceptance, and return to IDLE in the same cycle; no multiplier is synthesised.

Structure
REQ-029 Package vec_pkg SHALL hold the opcode enum, the FSM state typedef and the default parameter constants.
REQ-030 Sub-module vec_elem_alu SHALL implement the combinational per-element operation; vec_lane_seq holds the FSM, counters and pipeline registers.

Verification
REQ-031 SIZE_V=8, ADD v1 = {1..8}, v2 = {10..80 step 10}, vd=3 -> writes to reg 3 of {11,22,..,88} at T+3..T+10, done_o at T+10.
REQ-032 SUB 5-7 with DATA_LENGTH=8 -> 254; MUL 20*20 -> 144 (VEC_MUL_EN defined).
REQ-033 op 101 without VEC_MUL_EN -> illegal_o pulses once, zero rd_valid_o/wr_valid_o, instr_ready_o back 1 cycle later.
REQ-034 vd = vs1 = 2, XOR with all-0xFF -> reg 2 elements inverted, no element read after being overwritten.
REQ-035 instr_valid_i held high across 2 instructions -> second accepted at T+SIZE_V+3, no overlap of write streams.
REQ-036 rst_i asserted at READ element 4 -> no further writes, all outputs 0, instr_ready_o = 1 after release.

Source files
------------

// File: rtl/vec_pkg.sv
// vec_pkg: shared opcodes, FSM state encoding and default sizing for the vector lane sequencer.
`default_nettype none

package vec_pkg;

    localparam int c_size_v_default      = 8;
    localparam int c_reg_num_default     = 5;
    localparam int c_data_length_default = 8;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_MUL  = 3'b101,
        OP_MINU = 3'b110,
        OP_MAXU = 3'b111
    } op_e;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle  = 2'd0;
    localparam state_t c_st_read  = 2'd1;
    localparam state_t c_st_drain = 2'd2;

endpackage

`default_nettype wire

// File: rtl/vec_elem_alu.sv
// vec_elem_alu: combinational per-element operation; MUL is only built when VEC_MUL_EN is defined.
`default_nettype none

module vec_elem_alu
    import vec_pkg::*;
#(
    parameter int DATA_LENGTH = c_data_length_default
) (
    input  op_e                    op,
    input  logic [DATA_LENGTH-1:0] a,
    input  logic [DATA_LENGTH-1:0] b,
    output logic [DATA_LENGTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
`ifdef VEC_MUL_EN
            OP_MUL:  y = a * b;
`else
            OP_MUL:  y = '0;
`endif
            OP_MINU: y = (a < b) ? a : b;
            OP_MAXU: y = (a < b) ? b : a;
            default: y = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/vec_lane_seq.sv
// vec_lane_seq: element-serial vector instruction sequencer (IDLE/READ/DRAIN) over a registered-read file.
// Optional feature macro: VEC_MUL_EN (enables op 101 MUL; otherwise it is flagged illegal).
`default_nettype none

module vec_lane_seq
    import vec_pkg::*;
#(
    parameter int SIZE_V      = c_size_v_default,
    parameter int REG_NUM     = c_reg_num_default,
    parameter int DATA_LENGTH = c_data_length_default
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   instr_valid_i,
    output logic                   instr_ready_o,
    input  logic [2:0]             op_i,
    input  logic [REG_NUM-1:0]     vs1_i,
    input  logic [REG_NUM-1:0]     vs2_i,
    input  logic [REG_NUM-1:0]     vd_i,
    output logic [REG_NUM-1:0]     rd1_o,
    output logic [REG_NUM-1:0]     rd2_o,
    output logic                   rd_valid_o,
    input  logic [DATA_LENGTH-1:0] s1_i,
    input  logic [DATA_LENGTH-1:0] s2_i,
    output logic [REG_NUM-1:0]     wr_o,
    output logic [DATA_LENGTH-1:0] wr_d_o,
    output logic                   wr_valid_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   illegal_o
);

    localparam int CNT_W = (SIZE_V > 1) ? $clog2(SIZE_V) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(SIZE_V - 1);

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_drain;
    op_e                    r_op;
    logic [REG_NUM-1:0]     r_vs1;
    logic [REG_NUM-1:0]     r_vs2;
    logic [REG_NUM-1:0]     r_vd;
    logic                   r_stage_v;
    logic                   r_wr_valid;
    logic [DATA_LENGTH-1:0] r_wr_d;
    logic                   r_illegal;

    logic                   w_accept;
    logic                   w_op_illegal;
    logic [DATA_LENGTH-1:0] w_alu;

`ifdef VEC_MUL_EN
    assign w_op_illegal = 1'b0;
`else
    assign w_op_illegal = (op_i == OP_MUL);
`endif

    assign instr_ready_o = (r_state == c_st_idle) && !rst_i;
    assign w_accept      = instr_valid_i && instr_ready_o;

    vec_elem_alu #(
        .DATA_LENGTH(DATA_LENGTH)
    ) u_alu (
        .op(r_op),
        .a (s1_i),
        .b (s2_i),
        .y (w_alu)
    );

    // Two-stage pipe: read request -> operand valid (r_stage_v) -> registered result (r_wr_valid).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_st_idle;
            r_cnt      <= '0;
            r_drain    <= 1'b0;
            r_op       <= OP_ADD;
            r_vs1      <= '0;
            r_vs2      <= '0;
            r_vd       <= '0;
            r_stage_v  <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_d     <= '0;
            r_illegal  <= 1'b0;
        end else begin
            r_illegal  <= 1'b0;
            r_stage_v  <= (r_state == c_st_read);
            r_wr_valid <= r_stage_v;
            r_wr_d     <= r_stage_v ? w_alu : '0;
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_op  <= op_e'(op_i);
                        r_vs1 <= vs1_i;
                        r_vs2 <= vs2_i;
                        r_vd  <= vd_i;
                        r_cnt <= '0;
                        if (w_op_illegal) begin
                            r_illegal <= 1'b1;
                        end else begin
                            r_state <= c_st_read;
                        end
                    end
                end
                c_st_read: begin
                    if (r_cnt == c_last) begin
                        r_cnt   <= '0;
                        r_drain <= 1'b0;
                        r_state <= c_st_drain;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_drain: begin
                    // Second drain cycle carries the last write; leave right after it.
                    if (r_drain) begin
                        r_drain <= 1'b0;
                        r_state <= c_st_idle;
                    end else begin
                        r_drain <= 1'b1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign rd_valid_o = (r_state == c_st_read);
    assign rd1_o      = rd_valid_o ? r_vs1 : '0;
    assign rd2_o      = rd_valid_o ? r_vs2 : '0;
    assign wr_valid_o = r_wr_valid;
    assign wr_o       = r_wr_valid ? r_vd : '0;
    assign wr_d_o     = r_wr_d;
    assign busy_o     = (r_state != c_st_idle);
    assign done_o     = r_wr_valid && (r_state == c_st_drain) && r_drain;
    assign illegal_o  = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_vec_lane_seq.sv
// tb_vec_lane_seq: directed self-checking bench for vec_lane_seq with a registered-read register-file model.
`default_nettype none

module tb_vec_lane_seq;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       instr_valid_i = 1'b0;
    logic       instr_ready_o;
    logic [2:0] op_i = 3'b000;
    logic [4:0] vs1_i = '0, vs2_i = '0, vd_i = '0;
    logic [4:0] rd1_o, rd2_o, wr_o;
    logic       rd_valid_o, wr_valid_o, busy_o, done_o, illegal_o;
    logic [7:0] s1_i, s2_i, wr_d_o;

    int errors = 0;
    int checks = 0;
    int widx   = 0;

    logic [7:0] mem [32][8];
    logic [2:0] ridx;

    logic       tr_rd [32], tr_wr [32], tr_done [32], tr_ready [32], tr_busy [32], tr_ill [32];
    logic [7:0] tr_wd [32];
    logic [4:0] tr_wa [32], tr_rd1 [32], tr_rd2 [32];

    always #5 clk = ~clk;

    vec_lane_seq #(.SIZE_V(8), .REG_NUM(5), .DATA_LENGTH(8)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .op_i(op_i), .vs1_i(vs1_i), .vs2_i(vs2_i), .vd_i(vd_i),
        .rd1_o(rd1_o), .rd2_o(rd2_o), .rd_valid_o(rd_valid_o),
        .s1_i(s1_i), .s2_i(s2_i),
        .wr_o(wr_o), .wr_d_o(wr_d_o), .wr_valid_o(wr_valid_o),
        .busy_o(busy_o), .done_o(done_o), .illegal_o(illegal_o)
    );

    // Register file read side: data appears one cycle after each read request.
    always @(posedge clk) begin
        if (rst_i) begin
            ridx <= '0;
            s1_i <= '0;
            s2_i <= '0;
        end else if (rd_valid_o) begin
            s1_i <= mem[rd1_o][ridx];
            s2_i <= mem[rd2_o][ridx];
            ridx <= ridx + 3'd1;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic record(input int n);
        tr_rd[n]    = rd_valid_o;
        tr_wr[n]    = wr_valid_o;
        tr_done[n]  = done_o;
        tr_ready[n] = instr_ready_o;
        tr_busy[n]  = busy_o;
        tr_ill[n]   = illegal_o;
        tr_wd[n]    = wr_d_o;
        tr_wa[n]    = wr_o;
        tr_rd1[n]   = rd1_o;
        tr_rd2[n]   = rd2_o;
        if (wr_valid_o) begin
            mem[wr_o][widx % 8] = wr_d_o;
            widx++;
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input int ncyc);
        instr_valid_i = 1'b1;
        op_i = op; vs1_i = a; vs2_i = b; vd_i = d;
        widx = 0;
        step;
        instr_valid_i = 1'b0;
        for (int n = 1; n <= ncyc; n++) begin
            record(n);
            step;
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        step;
        step;
        checks++; if (instr_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", instr_ready_o); end
        checks++; if ({busy_o, rd_valid_o, wr_valid_o, done_o, illegal_o} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got=%b exp=00000", {busy_o, rd_valid_o, wr_valid_o, done_o, illegal_o}); end
        checks++; if ({rd1_o, rd2_o, wr_o, wr_d_o} !== 23'b0) begin
            errors++; $display("FAIL reset_buses got=%h exp=0", {rd1_o, rd2_o, wr_o, wr_d_o}); end
        rst_i = 1'b0;
        step;
        checks++; if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", instr_ready_o); end
    endtask

    task automatic test_add;
        logic [7:0] exp_v [8];
        logic e_rd, e_wr;
        exp_v = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77, 8'd88};
        for (int k = 0; k < 8; k++) begin
            mem[1][k] = 8'(k + 1);
            mem[2][k] = 8'(10 * (k + 1));
        end
        issue(3'b000, 5'd1, 5'd2, 5'd3, 11);
        for (int n = 1; n <= 11; n++) begin
            e_rd = (n <= 8);
            e_wr = (n >= 3) && (n <= 10);
            checks++; if (tr_rd[n] !== e_rd) begin errors++; $display("FAIL add_rd_valid n=%0d got=%b exp=%b", n, tr_rd[n], e_rd); end
            checks++; if (tr_wr[n] !== e_wr) begin errors++; $display("FAIL add_wr_valid n=%0d got=%b exp=%b", n, tr_wr[n], e_wr); end
            checks++; if (tr_done[n] !== (n == 10)) begin errors++; $display("FAIL add_done n=%0d got=%b", n, tr_done[n]); end
            checks++; if (tr_ready[n] !== (n == 11)) begin errors++; $display("FAIL add_ready n=%0d got=%b", n, tr_ready[n]); end
            checks++; if (tr_busy[n] !== (n <= 10)) begin errors++; $display("FAIL add_busy n=%0d got=%b", n, tr_busy[n]); end
            checks++; if (tr_ill[n] !== 1'b0) begin errors++; $display("FAIL add_illegal n=%0d got=%b exp=0", n, tr_ill[n]); end
            if (e_rd) begin
                checks++; if (tr_rd1[n] !== 5'd1 || tr_rd2[n] !== 5'd2) begin
                    errors++; $display("FAIL add_rd_addr n=%0d got=%0d,%0d exp=1,2", n, tr_rd1[n], tr_rd2[n]); end
            end
            if (e_wr) begin
                checks++; if (tr_wa[n] !== 5'd3) begin errors++; $display("FAIL add_wr_addr n=%0d got=%0d exp=3", n, tr_wa[n]); end
                checks++; if (tr_wd[n] !== exp_v[n-3]) begin errors++; $display("FAIL add_wr_data n=%0d got=%0d exp=%0d", n, tr_wd[n], exp_v[n-3]); end
            end
        end
    endtask

    task automatic test_alu_ops;
        logic [7:0] exp_t [5][8];
        logic [2:0] ops [5];
        int ndone;
        ops = '{3'b001, 3'b010, 3'b011, 3'b110, 3'b111};
        mem[4] = '{8'd5, 8'd5, 8'd100, 8'd0, 8'd255, 8'd7, 8'd128, 8'd1};
        mem[5] = '{8'd7, 8'd5, 8'd1, 8'd1, 8'd1, 8'd7, 8'd129, 8'd255};
        exp_t[0] = '{8'd254, 8'd0, 8'd99, 8'd255, 8'd254, 8'd0, 8'd255, 8'd2};
        exp_t[1] = '{8'd5, 8'd5, 8'd0, 8'd0, 8'd1, 8'd7, 8'd128, 8'd1};
        exp_t[2] = '{8'd7, 8'd5, 8'd101, 8'd1, 8'd255, 8'd7, 8'd129, 8'd255};
        exp_t[3] = '{8'd5, 8'd5, 8'd1, 8'd0, 8'd1, 8'd7, 8'd128, 8'd1};
        exp_t[4] = '{8'd7, 8'd5, 8'd100, 8'd1, 8'd255, 8'd7, 8'd129, 8'd255};
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], 5'd4, 5'd5, 5'(6 + i), 11);
            ndone = 0;
            for (int n = 1; n <= 11; n++) if (tr_done[n] === 1'b1) ndone++;
            checks++; if (ndone != 1) begin errors++; $display("FAIL alu_done_count op=%0d got=%0d exp=1", ops[i], ndone); end
            for (int n = 3; n <= 10; n++) begin
                checks++; if (tr_wr[n] !== 1'b1 || tr_wd[n] !== exp_t[i][n-3]) begin
                    errors++; $display("FAIL alu_wr op=%0d elem=%0d got=%0d(v=%b) exp=%0d", ops[i], n-3, tr_wd[n], tr_wr[n], exp_t[i][n-3]); end
            end
        end
    endtask

`ifdef VEC_MUL_EN
    task automatic test_mul;
        logic [7:0] exp_v [8];
        mem[11] = '{8'd20, 8'd2, 8'd255, 8'd16, 8'd0, 8'd3, 8'd128, 8'd15};
        mem[12] = '{8'd20, 8'd3, 8'd255, 8'd16, 8'd9, 8'd85, 8'd2, 8'd17};
        exp_v   = '{8'd144, 8'd6, 8'd1, 8'd0, 8'd0, 8'd255, 8'd0, 8'd255};
        issue(3'b101, 5'd11, 5'd12, 5'd13, 11);
        checks++; if (tr_ill[1] !== 1'b0) begin errors++; $display("FAIL mul_illegal got=%b exp=0", tr_ill[1]); end
        for (int n = 3; n <= 10; n++) begin
            checks++; if (tr_wr[n] !== 1'b1 || tr_wd[n] !== exp_v[n-3]) begin
                errors++; $display("FAIL mul_wr elem=%0d got=%0d exp=%0d", n-3, tr_wd[n], exp_v[n-3]); end
        end
    endtask
`else
    task automatic test_illegal;
        issue(3'b101, 5'd1, 5'd2, 5'd20, 4);
        checks++; if (tr_ill[1] !== 1'b1) begin errors++; $display("FAIL illegal_pulse got=%b exp=1", tr_ill[1]); end
        checks++; if (tr_ready[1] !== 1'b1) begin errors++; $display("FAIL illegal_ready got=%b exp=1", tr_ready[1]); end
        for (int n = 2; n <= 4; n++) begin
            checks++; if (tr_ill[n] !== 1'b0) begin errors++; $display("FAIL illegal_extra n=%0d got=%b exp=0", n, tr_ill[n]); end
        end
        for (int n = 1; n <= 4; n++) begin
            checks++; if ({tr_rd[n], tr_wr[n], tr_busy[n], tr_done[n]} !== 4'b0) begin
                errors++; $display("FAIL illegal_activity n=%0d got=%b exp=0000", n, {tr_rd[n], tr_wr[n], tr_busy[n], tr_done[n]}); end
        end
    endtask
`endif

    task automatic test_hazard;
        logic [7:0] exp_v [8];
        exp_v = '{8'd245, 8'd235, 8'd225, 8'd215, 8'd205, 8'd195, 8'd185, 8'd175};
        for (int k = 0; k < 8; k++) mem[14][k] = 8'hFF;
        issue(3'b100, 5'd2, 5'd14, 5'd2, 11);
        for (int n = 3; n <= 10; n++) begin
            checks++; if (tr_wa[n] !== 5'd2 || tr_wd[n] !== exp_v[n-3]) begin
                errors++; $display("FAIL hazard_wr elem=%0d got=%0d@%0d exp=%0d@2", n-3, tr_wd[n], tr_wa[n], exp_v[n-3]); end
        end
        for (int k = 0; k < 8; k++) begin
            checks++; if (mem[2][k] !== exp_v[k]) begin errors++; $display("FAIL hazard_reg elem=%0d got=%0d exp=%0d", k, mem[2][k], exp_v[k]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_b [8];
        logic e_rd, e_wr;
        int acc_n;
        exp_b = '{8'd7, 8'd5, 8'd101, 8'd1, 8'd255, 8'd7, 8'd129, 8'd255};
        acc_n = 0;
        widx = 0;
        instr_valid_i = 1'b1;
        op_i = 3'b000; vs1_i = 5'd1; vs2_i = 5'd1; vd_i = 5'd15;
        step;
        op_i = 3'b011; vs1_i = 5'd4; vs2_i = 5'd5; vd_i = 5'd16;
        for (int n = 1; n <= 22; n++) begin
            record(n);
            if (acc_n == 0 && tr_ready[n] === 1'b1) acc_n = n;
            step;
            if (acc_n != 0) instr_valid_i = 1'b0;
        end
        instr_valid_i = 1'b0;
        checks++; if (acc_n != 11) begin errors++; $display("FAIL b2b_second_accept got=%0d exp=11", acc_n); end
        for (int n = 1; n <= 22; n++) begin
            e_rd = (n <= 8) || (n >= 12 && n <= 19);
            e_wr = (n >= 3 && n <= 10) || (n >= 14 && n <= 21);
            checks++; if (tr_rd[n] !== e_rd || tr_wr[n] !== e_wr) begin
                errors++; $display("FAIL b2b_valids n=%0d got=%b%b exp=%b%b", n, tr_rd[n], tr_wr[n], e_rd, e_wr); end
            checks++; if (tr_done[n] !== (n == 10 || n == 21)) begin errors++; $display("FAIL b2b_done n=%0d got=%b", n, tr_done[n]); end
            if (n >= 3 && n <= 10) begin
                checks++; if (tr_wa[n] !== 5'd15 || tr_wd[n] !== 8'(2 * (n - 2))) begin
                    errors++; $display("FAIL b2b_first n=%0d got=%0d@%0d exp=%0d@15", n, tr_wd[n], tr_wa[n], 2 * (n - 2)); end
            end
            if (n >= 14 && n <= 21) begin
                checks++; if (tr_wa[n] !== 5'd16 || tr_wd[n] !== exp_b[n-14]) begin
                    errors++; $display("FAIL b2b_second n=%0d got=%0d@%0d exp=%0d@16", n, tr_wd[n], tr_wa[n], exp_b[n-14]); end
            end
        end
        checks++; if (tr_ready[22] !== 1'b1) begin errors++; $display("FAIL b2b_final_ready got=%b exp=1", tr_ready[22]); end
    endtask

    task automatic test_reset_mid;
        int nwr;
        widx = 0;
        instr_valid_i = 1'b1;
        op_i = 3'b000; vs1_i = 5'd1; vs2_i = 5'd1; vd_i = 5'd17;
        step;
        instr_valid_i = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            record(n);
            if (n < 5) step;
        end
        checks++; if (tr_rd[5] !== 1'b1) begin errors++; $display("FAIL rstmid_in_read got=%b exp=1", tr_rd[5]); end
        rst_i = 1'b1;
        step;
        checks++; if ({instr_ready_o, busy_o, rd_valid_o, wr_valid_o, done_o, illegal_o} !== 6'b0) begin
            errors++; $display("FAIL rstmid_flags got=%b exp=000000", {instr_ready_o, busy_o, rd_valid_o, wr_valid_o, done_o, illegal_o}); end
        checks++; if ({rd1_o, rd2_o, wr_o, wr_d_o} !== 23'b0) begin
            errors++; $display("FAIL rstmid_buses got=%h exp=0", {rd1_o, rd2_o, wr_o, wr_d_o}); end
        rst_i = 1'b0;
        step;
        checks++; if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", instr_ready_o); end
        nwr = 0;
        for (int n = 0; n < 6; n++) begin
            if (wr_valid_o === 1'b1 || rd_valid_o === 1'b1 || busy_o === 1'b1) nwr++;
            step;
        end
        checks++; if (nwr != 0) begin errors++; $display("FAIL rstmid_activity got=%0d exp=0", nwr); end
    endtask

    initial begin
        for (int r = 0; r < 32; r++)
            for (int k = 0; k < 8; k++) mem[r][k] = '0;
        test_reset;
        test_add;
        test_alu_ops;
`ifdef VEC_MUL_EN
        test_mul;
`else
        test_illegal;
`endif
        test_hazard;
        test_back_to_back;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
